// File: rtl/iter_ddot.sv
// ---------------------------------------------------------------------------
// iter_ddot -- iterative signed dot-product engine (one shared multiplier)
//
// Accepts one LANES-wide pair of signed vectors and reduces them one lane per
// cycle into a wide accumulator, then raises a one-cycle result strobe. A
// chained request adds onto the previous running sum, so vectors longer than
// LANES can be reduced in several passes. A request arriving while busy is
// dropped and sets a sticky overrun flag.
//
// Parameters:
//   DATA_W  signed operand element width
//   LANES   elements per vector = MAC cycles per operation (>= 1)
//   ACC_W   signed accumulator width (>= 2*DATA_W + clog2(LANES))
//   OUT_W   signed result width (<= ACC_W)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   ready  in   operand-valid strobe; accepted when busy=0
//   chain  in   1 = add onto previous running sum, 0 = start from zero
//   x, y   in   packed vectors, lane i at [i*DATA_W +: DATA_W]
//   busy   out  high while a MAC sequence is running
//   vld    out  one-cycle result strobe
//   z      out  formatted result, held until the next result
//   err    out  sticky overrun flag (request while busy), cleared by reset
//
// Configuration macro:
//   DDOT_SAT_EN  defined   -> result saturates to the signed OUT_W range
//                undefined -> result is the low OUT_W bits of the sum (wrap)
// ---------------------------------------------------------------------------
module iter_ddot #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ready,
    input  logic                      chain,
    input  logic [LANES*DATA_W-1:0]   x,
    input  logic [LANES*DATA_W-1:0]   y,
    output logic                      busy,
    output logic                      vld,
    output logic [OUT_W-1:0]          z,
    output logic                      err
);

    localparam int                IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [LANES*DATA_W-1:0]   xr;
    logic [LANES*DATA_W-1:0]   yr;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;

    logic                      accept;
    logic                      last;
    logic                      overrun;

    logic signed [DATA_W-1:0]   xa;
    logic signed [DATA_W-1:0]   ya;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic [OUT_W-1:0]           res;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control decodes
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        overrun   = 1'b0;
        case (state)
            IDLE: begin
                if (ready) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                // Any request while busy is dropped; the running op continues.
                overrun = ready;
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == MAC);

    // -----------------------------------------------------------------------
    // Datapath: one lane per cycle through a single signed multiplier
    // -----------------------------------------------------------------------
    assign xa       = xr[idx*DATA_W +: DATA_W];
    assign ya       = yr[idx*DATA_W +: DATA_W];
    assign prod     = xa * ya;
    // Signed size cast sign-extends the full-precision product.
    assign prod_ext = ACC_W'(prod);
    // Wraps modulo 2^ACC_W; never saturated, so chained sums stay exact.
    assign sum      = acc + prod_ext;

`ifdef DDOT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        res = sum[OUT_W-1:0];
        if (sum > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (sum < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    assign res = sum[OUT_W-1:0];
`endif

    // -----------------------------------------------------------------------
    // Operand capture
    // -----------------------------------------------------------------------
    // NOTE: the operand holding registers carry no reset: they are only read
    // in MAC, which is always entered through an accept that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            xr <= x;
            yr <= y;
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator, lane index, result and flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            idx <= '0;
            z   <= '0;
            vld <= 1'b0;
            err <= 1'b0;
        end else begin
            vld <= last;
            if (overrun) begin
                err <= 1'b1;
            end
            if (accept) begin
                idx <= '0;
                if (!chain) begin
                    acc <= '0;
                end
            end else if (state == MAC) begin
                acc <= sum;
                idx <= last ? '0 : idx + 1'b1;
                if (last) begin
                    z <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_ddot.sv
// ---------------------------------------------------------------------------
// tb_iter_ddot -- directed self-checking bench for iter_ddot
//
// Main instance uses the default parameters; a second instance with
// OUT_W=16 exercises result formatting (saturate vs wrap, selected by
// DDOT_SAT_EN). Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_iter_ddot;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;

    logic                    ready = 1'b0;
    logic                    chain = 1'b0;
    logic [LANES*DATA_W-1:0] x = '0;
    logic [LANES*DATA_W-1:0] y = '0;
    logic                    busy;
    logic                    vld;
    logic [31:0]             z;
    logic                    err;

    logic                    ready16 = 1'b0;
    logic [LANES*DATA_W-1:0] x16 = '0;
    logic [LANES*DATA_W-1:0] y16 = '0;
    logic                    busy16;
    logic                    vld16;
    logic [15:0]             z16;
    logic                    err16;

    int checks   = 0;
    int failures = 0;
    int vld_count = 0;

    always #5 clk = ~clk;

    iter_ddot u_dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .chain (chain),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .vld   (vld),
        .z     (z),
        .err   (err)
    );

    iter_ddot #(.OUT_W(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .ready (ready16),
        .chain (1'b0),
        .x     (x16),
        .y     (y16),
        .busy  (busy16),
        .vld   (vld16),
        .z     (z16),
        .err   (err16)
    );

    // Counts cycles in which the strobe is high (sampled before the edge).
    always @(posedge clk) begin
        if (vld) vld_count++;
    end

    function automatic logic [LANES*DATA_W-1:0] rep4(input logic [DATA_W-1:0] v);
        return {LANES{v}};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs,
                         input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for one edge, then drop ready.
    task automatic issue(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] yv,
                         input logic ch);
        @(negedge clk);
        ready = 1'b1;
        chain = ch;
        x     = rep4(xv);
        y     = rep4(yv);
        @(negedge clk);
        ready = 1'b0;
    endtask

    // Bounded wait for the result strobe on the main instance.
    task automatic wait_vld(input string tag);
        int n = 0;
        while (vld !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {47'd0, vld}, 48'd1);
    endtask

    initial begin
        int cnt0;

        // ---------------- reset state ----------------
        #22;
        check("rst_busy", {47'd0, busy}, 48'd0);
        check("rst_vld",  {47'd0, vld},  48'd0);
        check("rst_z",    {16'd0, z},    48'd0);
        check("rst_err",  {47'd0, err},  48'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- basic result and latency ----------------
        cnt0 = vld_count;
        issue(16'd1, 16'd1, 1'b0);          // negedge after E0
        for (int k = 0; k < 4; k++) begin   // after E0..E3
            check("lat_busy", {47'd0, busy}, 48'd1);
            check("lat_novld", {47'd0, vld}, 48'd0);
            @(negedge clk);
        end
        // after E4: result visible, sampled at E5
        check("lat_vld",  {47'd0, vld},  48'd1);
        check("lat_idle", {47'd0, busy}, 48'd0);
        check("basic_z",  {16'd0, z},    48'd4);
        @(negedge clk);
        check("vld_1cyc", {47'd0, vld},  48'd0);
        check("z_hold",   {16'd0, z},    48'd4);
        check("basic_pulses", 48'(vld_count - cnt0), 48'd1);

        // ---------------- signed operands ----------------
        issue(16'd2, 16'hFFFD, 1'b0);       // 4 * (2 * -3) = -24
        wait_vld("signed_vld");
        check("signed_z", {16'd0, z}, 48'h0000_FFFF_FFE8);
        @(negedge clk);

        // ---------------- chaining ----------------
        cnt0 = vld_count;
        issue(16'd1, 16'd2, 1'b0);          // op A: 8
        wait_vld("chainA_vld");
        check("chainA_z", {16'd0, z}, 48'd8);
        // op B accepted on the edge where A's vld is sampled
        ready = 1'b1;
        chain = 1'b1;
        x     = rep4(16'd1);
        y     = rep4(16'd1);
        @(negedge clk);
        ready = 1'b0;
        check("chainB_busy", {47'd0, busy}, 48'd1);
        wait_vld("chainB_vld");
        check("chainB_z", {16'd0, z}, 48'd12);
        @(negedge clk);
        check("chain_pulses", 48'(vld_count - cnt0), 48'd2);
        check("chain_noerr", {47'd0, err}, 48'd0);

        // ---------------- overrun ----------------
        cnt0 = vld_count;
        @(negedge clk);
        ready = 1'b1;
        chain = 1'b0;
        x     = rep4(16'd3);
        y     = rep4(16'd4);                // op A: 4*12 = 48
        @(negedge clk);                     // after E0; keep requesting
        x     = rep4(16'd5);
        y     = rep4(16'd5);
        check("ovr_busy", {47'd0, busy}, 48'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ovr_novld", {47'd0, vld}, 48'd0);
        end
        @(negedge clk);                     // after E4
        ready = 1'b0;
        check("ovr_vld", {47'd0, vld}, 48'd1);
        check("ovr_z",   {16'd0, z},   48'd48);
        check("ovr_err", {47'd0, err}, 48'd1);
        repeat (3) @(negedge clk);
        check("ovr_idle",   {47'd0, busy}, 48'd0);
        check("ovr_sticky", {47'd0, err},  48'd1);
        check("ovr_pulses", 48'(vld_count - cnt0), 48'd1);

        // ---------------- saturation vs wrap (OUT_W=16) ----------------
        @(negedge clk);
        ready16 = 1'b1;
        x16     = rep4(16'h7FFF);
        y16     = rep4(16'h7FFF);           // full sum 0xFFFC0004
        @(negedge clk);
        ready16 = 1'b0;
        begin
            int n = 0;
            while (vld16 !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("fmt_vld", {47'd0, vld16}, 48'd1);
`ifdef DDOT_SAT_EN
        check("fmt_z", {32'd0, z16}, 48'h7FFF);
`else
        check("fmt_z", {32'd0, z16}, 48'h0004);
`endif
        @(negedge clk);

        // ---------------- reset mid-op ----------------
        issue(16'd3, 16'd3, 1'b0);          // negedge after E0
        @(negedge clk);                     // 2nd MAC cycle
        check("mid_busy_pre", {47'd0, busy}, 48'd1);
        rst = 1'b0;
        #1;                                 // no clock edge in between
        check("mid_busy", {47'd0, busy}, 48'd0);
        check("mid_vld",  {47'd0, vld},  48'd0);
        check("mid_err",  {47'd0, err},  48'd0);
        check("mid_z",    {16'd0, z},    48'd0);
        @(negedge clk);
        rst = 1'b1;
        // chain=1 after reset must start from acc=0, not the partial sum
        issue(16'd2, 16'd2, 1'b1);
        wait_vld("post_vld");
        check("post_z", {16'd0, z}, 48'd16);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
